// File: rtl/mips_fetch_pkg.sv
// Shared fetch-side definitions: NOP encoding, I-cache FSM states and
// address-field width helpers.
package mips_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {IC_IDLE, IC_REQ, IC_FILL} icache_state_t;

  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned num_lines,
                                           input int unsigned line_words);
    return 32 - 2 - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Flop-based valid/tag/data arrays for the direct-mapped I-cache: one
// asynchronous read port, a data-word write port and a tag/valid write port.
module icache_line_store #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 26
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [$clog2(NUM_LINES)-1:0]  rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          wr_data_en,
  input  logic [$clog2(NUM_LINES)-1:0]  wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          wr_tv_en,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic                          wr_valid
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [31:0]          data_arr [NUM_LINES][LINE_WORDS];

  // Flush wins over a simultaneous install so a line finishing its fill
  // in the flush cycle is left invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_tv_en) begin
      valid[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_tv_en) begin
      tag_arr[wr_idx] <= wr_tag;
    end
    if (wr_data_en) begin
      data_arr[wr_idx][wr_word] <= wr_data;
    end
  end

  always_comb begin
    rd_valid = valid[rd_idx];
    rd_tag   = tag_arr[rd_idx];
    rd_data  = data_arr[rd_idx][rd_word];
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with req/ready + rvalid refill.
// Optional ICACHE_STATS_EN adds hit_count / miss_count outputs.
module icache_direct_mapped
  import mips_fetch_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        Fetch_Stall,
  input  logic        Icache_Flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OFF  = off_bits(LINE_WORDS);
  localparam int unsigned IDX  = idx_bits(NUM_LINES);
  localparam int unsigned TAGW = tag_bits(NUM_LINES, LINE_WORDS);
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

  icache_state_t state, state_n;
  logic [31:0]   miss_addr;
  logic [OFF-1:0] beat;
  logic          flush_pend;

  logic [OFF-1:0]  pc_word;
  logic [IDX-1:0]  pc_idx, miss_idx;
  logic [TAGW-1:0] pc_tag, miss_tag;
  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;
  logic [31:0]     rd_data;
  logic            hit, handshake, last_beat;
  logic            data_we, tv_we, tv_valid;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^PC[1:0];

  always_comb begin
    pc_word  = PC[OFF+1:2];
    pc_idx   = PC[OFF+IDX+1:OFF+2];
    pc_tag   = PC[31:OFF+IDX+2];
    miss_idx = miss_addr[OFF+IDX+1:OFF+2];
    miss_tag = miss_addr[31:OFF+IDX+2];
  end

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TAGW)
  ) u_store (
    .clk       (CLK),
    .rst_n     (RSTn),
    .flush     (Icache_Flush),
    .rd_idx    (pc_idx),
    .rd_word   (pc_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_data_en(data_we),
    .wr_idx    (miss_idx),
    .wr_word   (beat),
    .wr_data   (mem_rdata),
    .wr_tv_en  (tv_we),
    .wr_tag    (miss_tag),
    .wr_valid  (tv_valid)
  );

  always_comb begin
    hit         = (state == IC_IDLE) && !Icache_Flush && rd_valid && (rd_tag == pc_tag);
    Instr       = hit ? rd_data : NOP_INSTR;
    Fetch_Stall = !hit;
    mem_req     = (state == IC_REQ);
    mem_addr    = miss_addr;
    handshake   = (state == IC_REQ) && mem_ready;
    last_beat   = (state == IC_FILL) && mem_rvalid && (beat == LAST_BEAT);
    data_we     = (state == IC_FILL) && mem_rvalid;
    // The tag/valid port fires twice per refill: invalidate at FILL entry,
    // then install on the final beat (unless a flush hit the refill).
    tv_we       = handshake || last_beat;
    tv_valid    = last_beat && !flush_pend && !Icache_Flush;
  end

  always_comb begin
    state_n = state;
    case (state)
      IC_IDLE: if (!hit && !Icache_Flush) state_n = IC_REQ;
      IC_REQ:  if (mem_ready) state_n = IC_FILL;
      IC_FILL: if (last_beat) state_n = IC_IDLE;
      default: state_n = IC_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IC_IDLE;
      miss_addr  <= '0;
      beat       <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IC_IDLE && state_n == IC_REQ) begin
        miss_addr <= {PC[31:OFF+2], {(OFF+2){1'b0}}};
      end
      if (handshake) begin
        beat <= '0;
      end else if (data_we) begin
        beat <= beat + 1'b1;
      end
      if (state == IC_IDLE) begin
        flush_pend <= 1'b0;
      end else if (Icache_Flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) hit_count <= hit_count + 32'd1;
      if (state == IC_IDLE && state_n == IC_REQ) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: directed scenarios followed by
// random fetches against a line-level cache model. Honours ICACHE_STATS_EN.
module tb_icache_direct_mapped;

  localparam int unsigned NL = 16;
  localparam int unsigned LW = 4;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [31:0] PC = '0;
  logic        Icache_Flush = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] Instr, mem_addr;
  logic        Fetch_Stall, mem_req;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  icache_direct_mapped #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .CLK(CLK), .RSTn(RSTn), .PC(PC), .Instr(Instr), .Fetch_Stall(Fetch_Stall),
    .Icache_Flush(Icache_Flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Backing memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h20010005;
      32'h04:  return 32'h20020003;
      32'h08:  return 32'h00221820;
      32'h0C:  return 32'hAC030000;
      default: return {a[15:0] ^ 16'h5A3C, ~a[15:0]} + a;
    endcase
  endfunction

  // Memory responder: ready after rdelay REQ cycles, beats from the cycle
  // after acceptance, optional gaps, optional stray rvalid outside a fill.
  int unsigned rdelay = 1;
  bit          gaps_en = 0, stray_en = 0, hold_ready = 0, accept_pending = 0;
  int          beats_left = 0, beat_cnt = 0, beat_idx = -1;
  int unsigned req_wait = 0;
  logic [31:0] fill_base = '0;
  logic [31:0] req_log[$];

  initial forever begin
    @(negedge CLK);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    beat_idx   = -1;
    if (!RSTn) begin
      beats_left = 0; accept_pending = 0; req_wait = 0;
      if (stray_en) begin mem_rvalid = 1'b1; mem_rdata = $urandom; end
    end else begin
      if (accept_pending) begin
        accept_pending = 0; beats_left = LW; beat_cnt = 0;
      end
      if (beats_left > 0) begin
        if (!gaps_en || $urandom_range(0, 2) != 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(fill_base + 32'(4 * beat_cnt));
          beat_idx   = beat_cnt;
          beat_cnt++;
          beats_left--;
        end
      end else begin
        if (stray_en) begin mem_rvalid = 1'b1; mem_rdata = $urandom; end
        if (mem_req) begin
          if (!hold_ready && req_wait >= rdelay) begin
            mem_ready = 1'b1; accept_pending = 1; fill_base = mem_addr;
            req_log.push_back(mem_addr); req_wait = 0;
          end else begin
            req_wait++;
          end
        end else begin
          req_wait = 0;
        end
      end
    end
  end

  // Reference model: which line base address each set holds, if any
  bit          mvalid[NL];
  logic [31:0] mline[NL];
  int unsigned exp_misses = 0;

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a / (4 * LW)) % NL;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[set_of(a)] && mline[set_of(a)] == (a & ~32'(4 * LW - 1));
  endfunction

  task automatic model_install(input logic [31:0] a);
    mvalid[set_of(a)] = 1'b1;
    mline[set_of(a)]  = a & ~32'(4 * LW - 1);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEADBEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  bit nop_bad;

  // Called at negedge+1 with inputs set; returns at negedge+2 of the first
  // non-stalled cycle (or after the bound).
  task automatic wait_hit(input int bound, output int stalls);
    stalls = 0; nop_bad = 0;
    #1;
    while (Fetch_Stall !== 1'b0 && stalls < bound) begin
      if (Instr !== 32'h0) nop_bad = 1;
      @(negedge CLK); #2;
      stalls++;
    end
    check("stall_timeout", {31'b0, Fetch_Stall}, 32'd0);
  endtask

  task automatic post_fetch(input logic [31:0] pc, input bit exp_hit, input int nreq,
                            input int stalls, input bit exact, input int extra);
    check("instr", Instr, mem_word(pc & ~32'h3));
    if (exp_hit) begin
      check("hit_stalls", 32'(stalls), 32'd0);
      check("hit_noreq", 32'(req_log.size()), 32'(nreq));
    end else begin
      exp_misses++;
      check("miss_reqs", 32'(req_log.size()), 32'(nreq + 1));
      check("miss_addr", req_at(nreq), pc & ~32'(4 * LW - 1));
      check("stall_nop", {31'b0, nop_bad}, 32'd0);
      if (exact) check("miss_latency", 32'(stalls), 32'(2 + rdelay + LW + extra));
      model_install(pc);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input bit exact, input bit flush);
    int stalls, nreq;
    bit exp_hit;
    @(negedge CLK); #1;
    PC = pc;
    Icache_Flush = flush;
    if (flush) begin
      model_clear();
      #1 check("flush_forces_miss", {31'b0, Fetch_Stall}, 32'd1);
      @(negedge CLK); #1;
      Icache_Flush = 1'b0;
    end
    exp_hit = model_hit(pc);
    nreq = req_log.size();
    wait_hit(200, stalls);
    post_fetch(pc, exp_hit, nreq, stalls, exact, 0);
  endtask

  task automatic wait_beat(input int k);
    int n = 0;
    while (beat_idx != k && n < 100) begin @(negedge CLK); #1; n++; end
    check("beat_reached", 32'(beat_idx), 32'(k));
  endtask

  initial begin
    int stalls, nreq;
    logic [31:0] pc;
    model_clear();

    // Reset state
    repeat (2) @(negedge CLK);
    #2;
    check("rst_stall", {31'b0, Fetch_Stall}, 32'd1);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_instr", Instr, 32'h0);
`ifdef ICACHE_STATS_EN
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
`endif

    // 1: cold miss at 0x00 with one-cycle ready delay
    @(negedge CLK); #1;
    RSTn = 1'b1; PC = 32'h0;
    nreq = req_log.size();
    wait_hit(200, stalls);
    post_fetch(32'h0, 1'b0, nreq, stalls, 1'b1, 0);

    // 2: same-line hits
    fetch(32'h04, 1, 0);
    fetch(32'h08, 1, 0);
    fetch(32'h0C, 1, 0);

    // 3: conflict on set 0
    fetch(32'h40, 1, 0);
    fetch(32'h00, 1, 0);
`ifdef ICACHE_STATS_EN
    check("t3_misses", miss_count, 32'(exp_misses));
    // hit cycle of the final 0x00 fetch has not been clocked yet
    check("t3_hits", hit_count, 32'd5);
`endif

    // 4: redirect to 0x20 during beat 2 of the 0x10 refill
    nreq = req_log.size();
    @(negedge CLK); #1;
    PC = 32'h10;
    wait_beat(2);
    PC = 32'h20;
    wait_hit(200, stalls);
    check("redir_instr", Instr, mem_word(32'h20));
    check("redir_reqs", 32'(req_log.size()), 32'(nreq + 2));
    check("redir_first", req_at(nreq), 32'h10);
    check("redir_second", req_at(nreq + 1), 32'h20);
    model_install(32'h10); model_install(32'h20);
    exp_misses += 2;
    fetch(32'h10, 1, 0);

    // 5: flush on beat 1 of the 0x30 refill
    nreq = req_log.size();
    @(negedge CLK); #1;
    PC = 32'h30;
    wait_beat(1);
    Icache_Flush = 1'b1;
    model_clear();
    @(negedge CLK); #1;
    Icache_Flush = 1'b0;
    wait_hit(200, stalls);
    check("flush_instr", Instr, mem_word(32'h30));
    check("flush_reqs", 32'(req_log.size()), 32'(nreq + 2));
    check("flush_refetch", req_at(nreq + 1), 32'h30);
    model_install(32'h30);
    exp_misses += 2;
    fetch(32'h00, 1, 0);

    // 6: reset while waiting in REQ with memory not ready
    hold_ready = 1;
    @(negedge CLK); #1;
    PC = 32'h50;
    repeat (3) @(negedge CLK);
    #2;
    check("t6_req_held", {31'b0, mem_req}, 32'd1);
    check("t6_addr", mem_addr, 32'h50);
    @(negedge CLK); #1;
    RSTn = 1'b0; stray_en = 1;
    #1;
    @(negedge CLK); #2;
    check("t6_req_drop", {31'b0, mem_req}, 32'd0);
    check("t6_stall", {31'b0, Fetch_Stall}, 32'd1);
    model_clear();
    exp_misses = 0;
    @(negedge CLK); #1;
    RSTn = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    nreq = req_log.size();
    hold_ready = 0;
    wait_hit(200, stalls);
    post_fetch(32'h50, 1'b0, nreq, stalls, 1'b0, 0);
    stray_en = 0;
    fetch(32'h00, 1, 0);
    fetch(32'h14, 1, 0);
    fetch(32'h28, 1, 0);
    fetch(32'h3C, 1, 0);

    // Random fetches with varying memory timing and occasional flushes
    for (int i = 0; i < 150; i++) begin
      rdelay   = $urandom_range(0, 3);
      gaps_en  = ($urandom_range(0, 3) == 0);
      stray_en = $urandom_range(0, 1);
      pc = 32'($urandom_range(0, 255)) << 2 | 32'($urandom_range(0, 3));
      fetch(pc, !gaps_en, $urandom_range(0, 15) == 0);
    end
`ifdef ICACHE_STATS_EN
    check("final_misses", miss_count, 32'(exp_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
